// File: rtl/uart_pkg.sv
// Shared definitions for the uart_test datapath: FSM encoding, oversample
// rate and the default baud divider for the 50 MHz / 9600 baud build.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam int OVERSAMPLE = 16;

    // 50_000_000 / (16 * 9600) rounded
    localparam int DVSR_9600_AT_50MHZ = 326;

endpackage

// File: rtl/uart_tx_fifo_reader_baud_gen.sv
// Oversample tick divider: s_tick pulses once every DVSR clocks while running,
// and the counter is held at zero while clear is high.
module baud_gen #(
    parameter int DVSR = 326
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic s_tick
);

    localparam int W = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [W-1:0] LAST = W'(DVSR - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (clear || div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + W'(1);
        end
    end

    assign s_tick = (div_cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from a first-word-fall-through FIFO and
// sends them as start / DBIT data bits (LSB first) / stop frames on tx.
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = DVSR_9600_AT_50MHZ
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_rd_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic [1:0]      fsm_state
);

    localparam int TW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

    state_t          state, state_next;
    logic [TW-1:0]   tick_cnt, tick_next;
    logic [BW-1:0]   bit_cnt, bit_next;
    logic [DBIT-1:0] shift_reg, shift_next;
    logic            tx_next;
    logic            s_tick;
    logic            baud_clear;

    // Divider restarts from zero on the load cycle, so every frame has identical timing.
    assign baud_clear = (state == IDLE);

    baud_gen #(.DVSR(DVSR)) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (baud_clear),
        .s_tick (s_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        tick_next    = tick_cnt;
        bit_next     = bit_cnt;
        shift_next   = shift_reg;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so no pop is requested while held in reset.
                if (!fifo_empty && reset) begin
                    fifo_rd    = 1'b1;
                    shift_next = fifo_rd_data;
                    tick_next  = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_next  = '0;
                        state_next = DATA;
                    end else begin
                        tick_next = tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_next  = '0;
                        shift_next = shift_reg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            state_next = STOP;
                        end else begin
                            bit_next = bit_cnt + BW'(1);
                        end
                    end else begin
                        tick_next = tick_cnt + TW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        tick_next = tick_cnt + TW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the upcoming state so the line changes in step with it.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx_busy   = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench: idle, single and back-to-back frames, FIFO activity mid-frame,
// reset mid-frame, and a second instance with DVSR=3 / SB_TICK=32.
module tb_uart_tx_fifo_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd, tx, tx_busy, tx_done_tick;
    logic [1:0] fsm_state;

    logic       empty_b;
    logic [7:0] data_b;
    logic       rd_b, tx_b, busy_b, done_b;
    logic [1:0] state_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(16), .DVSR(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd      (fifo_rd),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .fsm_state    (fsm_state)
    );

    uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(32), .DVSR(3)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (empty_b),
        .fifo_rd_data (data_b),
        .fifo_rd      (rd_b),
        .tx           (tx_b),
        .tx_busy      (busy_b),
        .tx_done_tick (done_b),
        .fsm_state    (state_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the pop cycle T; walks T+1..T+320 of a DVSR=2 frame.
    task automatic watch_frame(input string tag, input logic [7:0] exp_byte,
                               input logic empty_after, input logic [7:0] new_data,
                               input logic toggle);
        int bad = 0;
        int rd_bad = 0;
        int busy_bad = 0;
        int done_bad = 0;
        logic [7:0] got = 8'h00;
        logic e;
        for (int n = 1; n <= 320; n++) begin
            step();
            if (n == 1) begin
                fifo_empty   = empty_after;
                fifo_rd_data = new_data;
            end
            if (toggle && n == 100) fifo_empty = 1'b0;
            if (toggle && n == 150) fifo_empty = 1'b1;
            if (n <= 32)       e = 1'b0;
            else if (n <= 288) e = exp_byte[(n - 33) / 32];
            else               e = 1'b1;
            if (tx !== e) bad++;
            if (n > 32 && n <= 288 && (n - 33) % 32 == 16) got[(n - 33) / 32] = tx;
            if (fifo_rd !== 1'b0) rd_bad++;
            if (tx_busy !== 1'b1) busy_bad++;
            if (tx_done_tick !== (n == 320)) done_bad++;
            #1;
        end
        check({tag, "_tx_wave_errs"}, bad, 0);
        check({tag, "_decoded"}, got, exp_byte);
        check({tag, "_extra_rd"}, rd_bad, 0);
        check({tag, "_busy_errs"}, busy_bad, 0);
        check({tag, "_done_errs"}, done_bad, 0);
    endtask

    initial begin
        int bad;
        int edges;
        int edge_at [16];
        int done_at;
        int busy_fall;
        logic prev;

        // Reset state, including a non-empty FIFO while held in reset
        reset        = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = 8'h00;
        empty_b      = 1'b1;
        data_b       = 8'h00;
        step();
        step();
        check("rst_tx", tx, 1);
        check("rst_rd", fifo_rd, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done_tick, 0);
        check("rst_state", fsm_state, 2'b00);
        check("rst_tx_b", tx_b, 1);
        fifo_empty = 1'b0;
        #1;
        check("rst_rd_gated", fifo_rd, 0);
        fifo_empty = 1'b1;
        step();
        reset = 1'b1;

        // Empty FIFO for 1000 clocks
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tx !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        check("idle_errs", bad, 0);

        // Single byte 0x55
        fifo_rd_data = 8'h55;
        fifo_empty   = 1'b0;
        #1;
        check("b55_rd_at_T", fifo_rd, 1);
        watch_frame("b55", 8'h55, 1'b1, 8'h00, 1'b0);
        step();
        check("b55_busy_fall", tx_busy, 0);
        check("b55_idle_tx", tx, 1);
        check("b55_no_rd", fifo_rd, 0);

        // Back-to-back A3 then 0F
        fifo_rd_data = 8'hA3;
        fifo_empty   = 1'b0;
        #1;
        check("bA3_rd_at_T", fifo_rd, 1);
        watch_frame("bA3", 8'hA3, 1'b0, 8'h0F, 1'b0);
        step();
        check("b2b_rd_after_done", fifo_rd, 1);
        check("b2b_idle_one_clk", tx_busy, 0);
        watch_frame("b0F", 8'h0F, 1'b1, 8'h00, 1'b0);
        step();
        check("b0F_busy_fall", tx_busy, 0);

        // FIFO toggling mid-frame is ignored
        fifo_rd_data = 8'hFF;
        fifo_empty   = 1'b0;
        #1;
        check("bFF_rd_at_T", fifo_rd, 1);
        watch_frame("bFF", 8'hFF, 1'b1, 8'hFF, 1'b1);
        step();
        check("bFF_busy_fall", tx_busy, 0);
        check("bFF_no_rd", fifo_rd, 0);

        // Reset in the middle of data bit 4
        fifo_rd_data = 8'h3C;
        fifo_empty   = 1'b0;
        #1;
        check("b3C_rd_at_T", fifo_rd, 1);
        step();
        fifo_empty = 1'b1;
        for (int i = 0; i < 174; i++) step();
        check("b3C_in_data", fsm_state, 2'b10);
        check("b3C_bit4", tx, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", tx_busy, 0);
        fifo_rd_data = 8'hC5;
        fifo_empty   = 1'b0;
        #1;
        check("mid_rst_rd_gated", fifo_rd, 0);
        step();
        reset = 1'b1;
        #1;
        check("post_rst_rd", fifo_rd, 1);
        watch_frame("bC5", 8'hC5, 1'b1, 8'h00, 1'b0);
        step();
        check("bC5_busy_fall", tx_busy, 0);

        // DVSR=3, SB_TICK=32: byte 0x35 -> edges at 1,49,97,145,193,241,337,433
        data_b  = 8'h35;
        empty_b = 1'b0;
        #1;
        check("dv3_rd_at_T", rd_b, 1);
        prev      = tx_b;
        edges     = 0;
        done_at   = 0;
        busy_fall = 0;
        for (int i = 0; i < 16; i++) edge_at[i] = 0;
        for (int n = 1; n <= 560; n++) begin
            step();
            if (n == 1) empty_b = 1'b1;
            if (tx_b !== prev) begin
                if (edges < 16) edge_at[edges] = n;
                edges++;
                prev = tx_b;
            end
            if (done_b === 1'b1 && done_at == 0) done_at = n;
            if (busy_b === 1'b0 && busy_fall == 0) busy_fall = n;
        end
        check("dv3_edge_count", edges, 8);
        check("dv3_start_edge", edge_at[0], 1);
        check("dv3_start_width", edge_at[1] - edge_at[0], 48);
        check("dv3_bit_width", edge_at[2] - edge_at[1], 48);
        check("dv3_two_bit_width", edge_at[6] - edge_at[5], 96);
        check("dv3_stop_edge", edge_at[7], 433);
        check("dv3_done_at", done_at, 528);
        check("dv3_stop_width", done_at - edge_at[7] + 1, 96);
        check("dv3_busy_fall", busy_fall, 529);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
